// File: rtl/pipeline_stall_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller_pkg
// Shared constants for the pipeline stall controller and its hazard unit:
//   REGISTER_FILE_ADDRESS_LEN - width of every register address in the pipe
//   sram_state_t              - SRAM wait-state FSM encoding
//   DEFAULT_SRAM_WAIT         - default cycles per MEM access (incl. request)
// ---------------------------------------------------------------------------
package pipeline_stall_controller_pkg;

    localparam int REGISTER_FILE_ADDRESS_LEN = 4;
    localparam int DEFAULT_SRAM_WAIT         = 4;

    typedef enum logic [1:0] {
        SRAM_IDLE   = 2'd0,
        SRAM_ACCESS = 2'd1,
        SRAM_DONE   = 2'd2
    } sram_state_t;

endpackage : pipeline_stall_controller_pkg

// File: rtl/pipeline_stall_controller_hazard_detection_unit.sv
// ---------------------------------------------------------------------------
// hazard_detection_unit
// Purely combinational RAW / load-use hazard detector for the ID stage.
// Ports:
//   src1, src2          - source register addresses of the ID instruction
//   has_src1, two_src   - which of those sources the instruction really reads
//   forward_en          - forwarding unit enabled
//   exe_dest, exe_wb_en, exe_mem_r_en - EXE stage destination / writeback / load
//   mem_dest, mem_wb_en - MEM stage destination / writeback
//   hazard              - ID instruction must be held back one cycle
// ---------------------------------------------------------------------------
module hazard_detection_unit
    import pipeline_stall_controller_pkg::*;
(
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] src1,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] src2,
    input  logic                                 has_src1,
    input  logic                                 two_src,
    input  logic                                 forward_en,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] exe_dest,
    input  logic                                 exe_wb_en,
    input  logic                                 exe_mem_r_en,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] mem_dest,
    input  logic                                 mem_wb_en,
    output logic                                 hazard
);

    logic exe_conflict;
    logic mem_conflict;

    always_comb begin
        exe_conflict = (has_src1 && (src1 == exe_dest)) || (two_src && (src2 == exe_dest));
        mem_conflict = (has_src1 && (src1 == mem_dest)) || (two_src && (src2 == mem_dest));

        // With forwarding only a load still in EXE cannot be bypassed in time;
        // without it every pending writer in EXE or MEM blocks the reader.
        if (forward_en) begin
            hazard = exe_wb_en && exe_mem_r_en && exe_conflict;
        end else begin
            hazard = (exe_wb_en && exe_conflict) || (mem_wb_en && mem_conflict);
        end
    end

endmodule : hazard_detection_unit

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
// Central freeze/flush sequencer for the IF/ID/EXE/MEM stage registers.
// Inserts ID bubbles on data hazards, flushes younger stages on a taken
// branch, freezes the whole pipe during multi-cycle SRAM accesses and counts
// stalled cycles in a saturating counter.
// Parameters:
//   SRAM_WAIT - total cycles per MEM access including the request cycle (2..16)
//   CNT_WIDTH - width of stall_count
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   src1/src2/has_src1/two_src  - ID instruction sources
//   forward_en                  - forwarding unit enabled
//   exe_* / mem_*               - EXE and MEM stage writer / memory info
//   branch_taken                - EXE resolved a taken branch
//   if_freeze, if_flush, id_freeze, id_flush, exe_freeze, mem_freeze
//                               - stage register controls (latency 0)
//   mem_ready                   - SRAM data valid this cycle
//   stall_count                 - cycles with any freeze asserted (saturating)
//   fsm_state                   - current SRAM FSM state, for observation
// All outputs are forced to 0 while rst is high.
// ---------------------------------------------------------------------------
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int SRAM_WAIT = DEFAULT_SRAM_WAIT,
    parameter int CNT_WIDTH = 32
)
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] src1,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] src2,
    input  logic                                 has_src1,
    input  logic                                 two_src,
    input  logic                                 forward_en,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] exe_dest,
    input  logic                                 exe_wb_en,
    input  logic                                 exe_mem_r_en,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] mem_dest,
    input  logic                                 mem_wb_en,
    input  logic                                 mem_r_en,
    input  logic                                 mem_w_en,
    input  logic                                 branch_taken,
    output logic                                 if_freeze,
    output logic                                 if_flush,
    output logic                                 id_freeze,
    output logic                                 id_flush,
    output logic                                 exe_freeze,
    output logic                                 mem_freeze,
    output logic                                 mem_ready,
    output logic [CNT_WIDTH-1:0]                 stall_count,
    output logic [1:0]                           fsm_state
);

    // Wide enough for the largest preload, SRAM_WAIT-3 = 13.
    localparam int WAIT_CNT_W = 4;

    sram_state_t           state_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [CNT_WIDTH-1:0]  stall_cnt_q;

    logic hazard;
    logic mem_req;
    logic mem_stall;

    hazard_detection_unit u_hazard (
        .src1         (src1),
        .src2         (src2),
        .has_src1     (has_src1),
        .two_src      (two_src),
        .forward_en   (forward_en),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    // A request in DONE is the retiring access itself, so only IDLE starts a
    // new one; DONE is never frozen, which lets MEM hand its data on.
    always_comb begin
        mem_req   = mem_r_en || mem_w_en;
        mem_stall = ((state_q == SRAM_IDLE) && mem_req) || (state_q == SRAM_ACCESS);
    end

    // Priority: memory freeze, then branch flush, then hazard bubble. While
    // frozen the branch/hazard inputs stay put and take effect afterwards.
    always_comb begin
        if_freeze   = 1'b0;
        if_flush    = 1'b0;
        id_freeze   = 1'b0;
        id_flush    = 1'b0;
        exe_freeze  = 1'b0;
        mem_freeze  = 1'b0;
        mem_ready   = 1'b0;
        stall_count = '0;
        fsm_state   = 2'd0;
        if (!rst) begin
            id_freeze   = mem_stall;
            exe_freeze  = mem_stall;
            mem_freeze  = mem_stall;
            if_freeze   = mem_stall || (hazard && !branch_taken);
            if_flush    = branch_taken && !mem_stall;
            id_flush    = (branch_taken || hazard) && !mem_stall;
            mem_ready   = (state_q == SRAM_DONE);
            stall_count = stall_cnt_q;
            fsm_state   = state_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SRAM_IDLE;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                SRAM_IDLE: begin
                    if (mem_req) begin
                        if (SRAM_WAIT == 2) begin
                            state_q <= SRAM_DONE;
                        end else begin
                            state_q    <= SRAM_ACCESS;
                            wait_cnt_q <= WAIT_CNT_W'(SRAM_WAIT - 3);
                        end
                    end
                end
                SRAM_ACCESS: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= SRAM_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                SRAM_DONE: begin
                    state_q <= SRAM_IDLE;
                end
                default: begin
                    state_q <= SRAM_IDLE;
                end
            endcase

            if ((if_freeze || id_freeze) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

endmodule : pipeline_stall_controller

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
// Bench for pipeline_stall_controller. dut uses SRAM_WAIT=4 / 32-bit counter,
// dut2 uses SRAM_WAIT=2 / 2-bit counter (back-to-back and saturation).
// Each scoreboard entry is {state[1:0], stall_count[31:0], outputs[6:0]},
// outputs = {if_freeze, if_flush, id_freeze, id_flush, exe_freeze,
//            mem_freeze, mem_ready}.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic       has_src1, two_src, forward_en, exe_wb_en, exe_mem_r_en;
    logic       mem_wb_en, mem_r_en, mem_w_en, branch_taken;

    logic        if_freeze, if_flush, id_freeze, id_flush, exe_freeze, mem_freeze, mem_ready;
    logic [31:0] stall_count;
    logic [1:0]  fsm_state;
    logic        if_freeze2, if_flush2, id_freeze2, id_flush2, exe_freeze2, mem_freeze2, mem_ready2;
    logic [1:0]  stall_count2;
    logic [1:0]  fsm_state2;

    logic [6:0] obs_vec, obs_vec2;
    assign obs_vec  = {if_freeze, if_flush, id_freeze, id_flush, exe_freeze, mem_freeze, mem_ready};
    assign obs_vec2 = {if_freeze2, if_flush2, id_freeze2, id_flush2, exe_freeze2, mem_freeze2, mem_ready2};

    pipeline_stall_controller #(.SRAM_WAIT(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .has_src1(has_src1),
        .two_src(two_src), .forward_en(forward_en), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .branch_taken(branch_taken), .if_freeze(if_freeze), .if_flush(if_flush),
        .id_freeze(id_freeze), .id_flush(id_flush), .exe_freeze(exe_freeze),
        .mem_freeze(mem_freeze), .mem_ready(mem_ready), .stall_count(stall_count),
        .fsm_state(fsm_state)
    );

    pipeline_stall_controller #(.SRAM_WAIT(2), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .has_src1(has_src1),
        .two_src(two_src), .forward_en(forward_en), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .branch_taken(branch_taken), .if_freeze(if_freeze2), .if_flush(if_flush2),
        .id_freeze(id_freeze2), .id_flush(id_flush2), .exe_freeze(exe_freeze2),
        .mem_freeze(mem_freeze2), .mem_ready(mem_ready2), .stall_count(stall_count2),
        .fsm_state(fsm_state2)
    );

    // ---------------- expected values ----------------
    localparam logic [6:0] V_NONE        = 7'b0000000;
    localparam logic [6:0] V_BUBBLE      = 7'b1001000;
    localparam logic [6:0] V_FREEZE      = 7'b1010110;
    localparam logic [6:0] V_READY       = 7'b0000001;
    localparam logic [6:0] V_FLUSH       = 7'b0101000;
    localparam logic [6:0] V_FLUSH_READY = 7'b0101001;
    localparam logic [1:0] S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2;

    logic [40:0] exp_q[$];
    logic [31:0] exp_cnt = 32'd0;
    int          checks = 0;
    int          errors = 0;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        rst = 1'b0; src1 = 4'd0; src2 = 4'd0; has_src1 = 1'b0; two_src = 1'b0;
        forward_en = 1'b0; exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic drive_load_use(input logic [3:0] reg_addr);
        forward_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1;
        exe_dest = reg_addr; src1 = reg_addr; has_src1 = 1'b1;
    endtask

    // Expected stall_count is whatever the model holds, forced to 0 under rst.
    task automatic push_expect(input logic [6:0] v, input logic [1:0] st);
        exp_q.push_back({st, (rst ? 32'd0 : exp_cnt), v});
    endtask

    // Step the stall-count model across the rising edge, then move off it.
    task automatic advance(input logic [6:0] v, input logic sat2);
        @(posedge clk);
        if (rst) exp_cnt = 32'd0;
        else if (v[6] || v[4]) begin
            if (sat2) exp_cnt = (exp_cnt == 32'd3) ? 32'd3 : exp_cnt + 32'd1;
            else if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 32'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [6:0] v; logic [1:0] st; logic [40:0] ent;
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            v = V_NONE; st = S_IDLE;
            if (i < 2) begin
                rst = 1'b1;
                drive_load_use(4'd3);
                mem_r_en = 1'b1;
                branch_taken = 1'b1;
            end
            push_expect(v, st);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL reset[%0d] scoreboard empty", i);
            end else begin
                ent = exp_q.pop_front();
                checks++;
                if (obs_vec !== ent[6:0]) begin errors++; $display("FAIL reset[%0d] outputs got %b expected %b", i, obs_vec, ent[6:0]); end
                checks++;
                if (stall_count !== ent[38:7]) begin errors++; $display("FAIL reset[%0d] stall_count got %0d expected %0d", i, stall_count, ent[38:7]); end
                checks++;
                if (fsm_state !== ent[40:39]) begin errors++; $display("FAIL reset[%0d] state got %0d expected %0d", i, fsm_state, ent[40:39]); end
            end
            advance(v, 1'b0);
        end
    endtask

    task automatic test_load_use();
        logic [6:0] v; logic [40:0] ent;
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            v = V_NONE;
            case (i)
                0: begin drive_load_use(4'd3); v = V_BUBBLE; end
                1: begin drive_load_use(4'd3); exe_mem_r_en = 1'b0; end   // forwardable ALU result
                2: begin drive_load_use(4'd9); src1 = 4'd8; end           // different register
                default: ;
            endcase
            push_expect(v, S_IDLE);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL load_use[%0d] scoreboard empty", i);
            end else begin
                ent = exp_q.pop_front();
                checks++;
                if (obs_vec !== ent[6:0]) begin errors++; $display("FAIL load_use[%0d] outputs got %b expected %b", i, obs_vec, ent[6:0]); end
                checks++;
                if (stall_count !== ent[38:7]) begin errors++; $display("FAIL load_use[%0d] stall_count got %0d expected %0d", i, stall_count, ent[38:7]); end
            end
            advance(v, 1'b0);
        end
    endtask

    task automatic test_no_forward();
        logic [6:0] v; logic [40:0] ent;
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            v = V_NONE;
            case (i)
                0: begin mem_wb_en = 1'b1; mem_dest = 4'd5; two_src = 1'b1; src2 = 4'd5; v = V_BUBBLE; end
                1: begin mem_wb_en = 1'b1; mem_dest = 4'd5; src2 = 4'd5; src1 = 4'd5; end
                2: begin exe_wb_en = 1'b1; exe_dest = 4'd7; has_src1 = 1'b1; src1 = 4'd7; v = V_BUBBLE; end
                3: begin exe_wb_en = 1'b1; exe_dest = 4'd7; has_src1 = 1'b1; src1 = 4'd7; forward_en = 1'b1; end
                default: begin
                    mem_wb_en = 1'b0; mem_dest = 4'd12; has_src1 = 1'b1;
                    src1 = 4'($urandom_range(0, 15)); two_src = 1'b1; src2 = 4'($urandom_range(0, 15));
                end
            endcase
            push_expect(v, S_IDLE);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL no_forward[%0d] scoreboard empty", i);
            end else begin
                ent = exp_q.pop_front();
                checks++;
                if (obs_vec !== ent[6:0]) begin errors++; $display("FAIL no_forward[%0d] outputs got %b expected %b", i, obs_vec, ent[6:0]); end
                checks++;
                if (stall_count !== ent[38:7]) begin errors++; $display("FAIL no_forward[%0d] stall_count got %0d expected %0d", i, stall_count, ent[38:7]); end
            end
            advance(v, 1'b0);
        end
    endtask

    task automatic test_sram_wait();
        logic [6:0] v; logic [1:0] st; logic [40:0] ent;
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            if (i < 4) mem_r_en = 1'b1;
            if (i == 1) drive_load_use(4'd2);   // bubble deferred while frozen
            case (i)
                0: begin v = V_FREEZE; st = S_IDLE;   end
                1: begin v = V_FREEZE; st = S_ACCESS; end
                2: begin v = V_FREEZE; st = S_ACCESS; end
                3: begin v = V_READY;  st = S_DONE;   end
                default: begin v = V_NONE; st = S_IDLE; end
            endcase
            push_expect(v, st);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL sram_wait[%0d] scoreboard empty", i);
            end else begin
                ent = exp_q.pop_front();
                checks++;
                if (obs_vec !== ent[6:0]) begin errors++; $display("FAIL sram_wait[%0d] outputs got %b expected %b", i, obs_vec, ent[6:0]); end
                checks++;
                if (stall_count !== ent[38:7]) begin errors++; $display("FAIL sram_wait[%0d] stall_count got %0d expected %0d", i, stall_count, ent[38:7]); end
                checks++;
                if (fsm_state !== ent[40:39]) begin errors++; $display("FAIL sram_wait[%0d] state got %0d expected %0d", i, fsm_state, ent[40:39]); end
            end
            advance(v, 1'b0);
        end
    endtask

    task automatic test_branch();
        logic [6:0] v; logic [1:0] st; logic [40:0] ent;
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            v = V_NONE; st = S_IDLE;
            case (i)
                0: begin drive_load_use(4'd4); branch_taken = 1'b1; v = V_FLUSH; end
                1: begin branch_taken = 1'b1; v = V_FLUSH; end
                2: begin mem_w_en = 1'b1; v = V_FREEZE; end
                3: begin mem_w_en = 1'b1; branch_taken = 1'b1; v = V_FREEZE; st = S_ACCESS; end
                4: begin mem_w_en = 1'b1; branch_taken = 1'b1; v = V_FREEZE; st = S_ACCESS; end
                5: begin mem_w_en = 1'b1; branch_taken = 1'b1; v = V_FLUSH_READY; st = S_DONE; end
                default: ;
            endcase
            push_expect(v, st);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL branch[%0d] scoreboard empty", i);
            end else begin
                ent = exp_q.pop_front();
                checks++;
                if (obs_vec !== ent[6:0]) begin errors++; $display("FAIL branch[%0d] outputs got %b expected %b", i, obs_vec, ent[6:0]); end
                checks++;
                if (stall_count !== ent[38:7]) begin errors++; $display("FAIL branch[%0d] stall_count got %0d expected %0d", i, stall_count, ent[38:7]); end
                checks++;
                if (fsm_state !== ent[40:39]) begin errors++; $display("FAIL branch[%0d] state got %0d expected %0d", i, fsm_state, ent[40:39]); end
            end
            advance(v, 1'b0);
        end
    endtask

    // dut2: SRAM_WAIT=2 alternates freeze/ready; 2-bit counter saturates at 3.
    task automatic test_back_to_back();
        logic [6:0] v; logic [1:0] st; logic [40:0] ent;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            if (i < 8) begin
                mem_r_en = 1'b1;
                v  = (i % 2 == 0) ? V_FREEZE : V_READY;
                st = (i % 2 == 0) ? S_IDLE : S_DONE;
            end else begin
                v = V_NONE; st = S_IDLE;
            end
            push_expect(v, st);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL back_to_back[%0d] scoreboard empty", i);
            end else begin
                ent = exp_q.pop_front();
                checks++;
                if (obs_vec2 !== ent[6:0]) begin errors++; $display("FAIL back_to_back[%0d] outputs got %b expected %b", i, obs_vec2, ent[6:0]); end
                checks++;
                if ({30'd0, stall_count2} !== ent[38:7]) begin errors++; $display("FAIL back_to_back[%0d] stall_count got %0d expected %0d", i, stall_count2, ent[38:7]); end
                checks++;
                if (fsm_state2 !== ent[40:39]) begin errors++; $display("FAIL back_to_back[%0d] state got %0d expected %0d", i, fsm_state2, ent[40:39]); end
            end
            advance(v, 1'b1);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [6:0] v; logic [1:0] st; logic [40:0] ent;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            v = V_NONE; st = S_IDLE;
            case (i)
                0: begin mem_r_en = 1'b1; v = V_FREEZE; end
                1: begin mem_r_en = 1'b1; rst = 1'b1; end           // ACCESS cycle 2
                2: ;                                                 // back in IDLE
                default: begin mem_r_en = 1'b1; v = V_FREEZE; end   // fresh request
            endcase
            push_expect(v, st);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL reset_mid_access[%0d] scoreboard empty", i);
            end else begin
                ent = exp_q.pop_front();
                checks++;
                if (obs_vec !== ent[6:0]) begin errors++; $display("FAIL reset_mid_access[%0d] outputs got %b expected %b", i, obs_vec, ent[6:0]); end
                checks++;
                if (stall_count !== ent[38:7]) begin errors++; $display("FAIL reset_mid_access[%0d] stall_count got %0d expected %0d", i, stall_count, ent[38:7]); end
                checks++;
                if (fsm_state !== ent[40:39]) begin errors++; $display("FAIL reset_mid_access[%0d] state got %0d expected %0d", i, fsm_state, ent[40:39]); end
            end
            advance(v, 1'b0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_no_forward();
        test_sram_wait();
        test_branch();
        test_back_to_back();
        test_reset_mid_access();
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, run did not complete");
        $fatal(1, "watchdog");
    end

endmodule : tb_pipeline_stall_controller
